// File: rtl/div_cnt_pkg.sv
// ---------------------------------------------------------------------------
// div_cnt_pkg
// Shared types and constants for the div_cnt_gen clock divider / counter.
//   state_e : HOLD (counting frozen) / RUN (counting enabled)
//   mode_e  : MODE_TOGGLE (50% duty output) / MODE_PULSE (output mirrors tc)
//   WIDTH_MIN / WIDTH_MAX : legal range of the WIDTH parameter
// ---------------------------------------------------------------------------
package div_cnt_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

endpackage : div_cnt_pkg

// File: rtl/div_cnt_gen_if.sv
// ---------------------------------------------------------------------------
// div_cnt_gen_if
// Valid/ready channel used to hand a new period to div_cnt_gen.
//   div_valid : master -> slave, a period is offered
//   div_value : master -> slave, offered period (WIDTH bits)
//   div_ready : slave -> master, the block can take a period
// A transfer happens in any cycle where div_valid and div_ready are both 1.
// ---------------------------------------------------------------------------
interface div_cnt_gen_if #(
  parameter int WIDTH = 4
);

  logic             div_valid;
  logic [WIDTH-1:0] div_value;
  logic             div_ready;

  modport master (
    output div_valid,
    output div_value,
    input  div_ready
  );

  modport slave (
    input  div_valid,
    input  div_value,
    output div_ready
  );

endinterface : div_cnt_gen_if

// File: rtl/div_cfg_shadow.sv
// ---------------------------------------------------------------------------
// div_cfg_shadow
// Accepts new periods over the valid/ready channel and parks them in a
// shadow register until the counter is ready to use them.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (drops any pending value)
//   load_i     : counter reload or restart this cycle; consumes a pending value
//   bypass_i   : restart this cycle; a same-cycle transfer goes straight to
//                the counter instead of the shadow register
//   bus        : period channel (slave side), drives div_ready
//   pend_o     : shadow register holds a value not yet applied
//   val_o      : shadow register contents
//   xfer_ok_o  : a non-zero period is transferring this cycle
//   cfg_err_o  : sticky, a zero period was offered and accepted
// ---------------------------------------------------------------------------
module div_cfg_shadow #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             bypass_i,
  div_cnt_gen_if.slave     bus,
  output logic             pend_o,
  output logic [WIDTH-1:0] val_o,
  output logic             xfer_ok_o,
  output logic             cfg_err_o
);

  logic             rdy_q, rdy_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             xfer;
  logic             zero_val;

  assign xfer     = bus.div_valid & rdy_q;
  assign zero_val = (bus.div_value == '0);

  always_comb begin
    rdy_d  = rdy_q;
    pend_d = pend_q;
    err_d  = err_q;
    val_d  = val_q;
    if (xfer) begin
      if (zero_val) begin
        // Zero period completes the handshake but is thrown away.
        err_d = 1'b1;
      end else if (!bypass_i) begin
        val_d  = bus.div_value;
        pend_d = 1'b1;
        rdy_d  = 1'b0;
      end
    end else if (pend_q && load_i) begin
      // Value is now the active period; ready comes back one cycle later.
      pend_d = 1'b0;
    end else if (!pend_q && !rdy_q) begin
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q  <= 1'b1;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rdy_q  <= rdy_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // Shadow data is qualified by pend_q, so it carries no reset.
  always_ff @(posedge clk) begin
    val_q <= val_d;
  end

  assign bus.div_ready = rdy_q;
  assign pend_o        = pend_q;
  assign val_o         = val_q;
  assign xfer_ok_o     = xfer & ~zero_val;
  assign cfg_err_o     = err_q;

endmodule : div_cfg_shadow

// File: rtl/div_cnt_gen.sv
// ---------------------------------------------------------------------------
// div_cnt_gen
// Programmable down-counter / clock divider. The counter runs P, P-1, ..., 1
// on enabled cycles and reloads P after 1, raising tc for one cycle. f_out
// toggles at each reload (period 2*P, 50% duty) or, in pulse mode, follows tc.
// New periods arrive over a valid/ready channel and take effect at the next
// reload or restart.
//
// Optional feature: define DIV_CNT_PULSE_MODE_EN to honour the mode input
// (pulse output). Without it the mode input is ignored and only toggle
// behaviour exists.
//
// Parameters
//   WIDTH   : counter / period width, 2..16
//   DEF_DIV : period after reset, 1..2^WIDTH-1
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, dominates everything
//   en       : count enable; low freezes counter and outputs (HOLD)
//   restart  : reload counter with P (or pending / same-cycle period), clear f_out
//   mode     : 0 toggle output, 1 pulse output (pulse build only)
//   bus      : period channel (slave side)
//   cnt_out  : current count
//   f_out    : divided output
//   tc       : one-cycle terminal-count strobe
//   cfg_err  : sticky zero-period flag
// ---------------------------------------------------------------------------
module div_cnt_gen
  import div_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEF_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             mode,
  div_cnt_gen_if.slave     bus,
  output logic [WIDTH-1:0] cnt_out,
  output logic             f_out,
  output logic             tc,
  output logic             cfg_err
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
    $error("div_cnt_gen: WIDTH out of range");
  end
  if (DEF_DIV < 1 || DEF_DIV > ((1 << WIDTH) - 1)) begin : g_def_chk
    $error("div_cnt_gen: DEF_DIV out of range");
  end

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] per_nxt;
  logic             f_q, f_d;
  logic             tc_q, tc_d;
  logic             consume;

  logic             sh_pend;
  logic [WIDTH-1:0] sh_val;
  logic             sh_xfer_ok;

`ifdef DIV_CNT_PULSE_MODE_EN
  mode_e            mode_q, mode_d;
`else
  logic             unused_mode;
  assign unused_mode = mode;
`endif

  div_cfg_shadow #(
    .WIDTH (WIDTH)
  ) u_cfg_shadow (
    .clk       (clk),
    .rst       (rst),
    .load_i    (consume),
    .bypass_i  (restart),
    .bus       (bus),
    .pend_o    (sh_pend),
    .val_o     (sh_val),
    .xfer_ok_o (sh_xfer_ok),
    .cfg_err_o (cfg_err)
  );

  always_comb begin
    state_d = en ? RUN : HOLD;
    cnt_d   = cnt_q;
    per_d   = per_q;
    f_d     = f_q;
    tc_d    = 1'b0;
    consume = 1'b0;
    per_nxt = sh_pend ? sh_val : per_q;
`ifdef DIV_CNT_PULSE_MODE_EN
    mode_d  = mode_q;
`endif
    if (restart) begin
      // Restart works in HOLD too; a same-cycle transfer bypasses the shadow.
      if (sh_pend) begin
        per_d = sh_val;
      end else if (sh_xfer_ok) begin
        per_d = bus.div_value;
      end
      cnt_d   = per_d;
      f_d     = 1'b0;
      consume = 1'b1;
`ifdef DIV_CNT_PULSE_MODE_EN
      mode_d  = mode_e'(mode);
`endif
    end else if (state_d == RUN) begin
      // Treat any count <= 1 as terminal so the counter never goes below 1.
      if (cnt_q <= ONE) begin
        per_d   = per_nxt;
        cnt_d   = per_nxt;
        tc_d    = 1'b1;
        consume = 1'b1;
`ifdef DIV_CNT_PULSE_MODE_EN
        // Mode changes are picked up only here, never mid-period.
        mode_d  = mode_e'(mode);
        f_d     = (mode_e'(mode) == MODE_PULSE) ? 1'b1 : ~f_q;
`else
        f_d     = ~f_q;
`endif
      end else begin
        cnt_d = cnt_q - ONE;
`ifdef DIV_CNT_PULSE_MODE_EN
        if (mode_q == MODE_PULSE) begin
          f_d = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= DEF_P;
      per_q   <= DEF_P;
      f_q     <= 1'b0;
      tc_q    <= 1'b0;
`ifdef DIV_CNT_PULSE_MODE_EN
      mode_q  <= MODE_TOGGLE;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      f_q     <= f_d;
      tc_q    <= tc_d;
`ifdef DIV_CNT_PULSE_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign cnt_out = cnt_q;
  assign tc      = tc_q & (state_q == RUN);
`ifdef DIV_CNT_PULSE_MODE_EN
  assign f_out   = (mode_q == MODE_PULSE) ? tc : f_q;
`else
  assign f_out   = f_q;
`endif

endmodule : div_cnt_gen

// File: tb/tb_div_cnt_gen.sv
// ---------------------------------------------------------------------------
// tb_div_cnt_gen
// Directed bench for div_cnt_gen (WIDTH=4, DEF_DIV=10). Pulse-mode
// expectations follow the DIV_CNT_PULSE_MODE_EN build setting.
// ---------------------------------------------------------------------------
module tb_div_cnt_gen;

  localparam int WIDTH   = 4;
  localparam int DEF_DIV = 10;

`ifdef DIV_CNT_PULSE_MODE_EN
  localparam bit PULSE_BUILD = 1'b1;
`else
  localparam bit PULSE_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             restart;
  logic             mode;
  logic [WIDTH-1:0] cnt_out;
  logic             f_out;
  logic             tc;
  logic             cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_cnt_gen_if #(.WIDTH(WIDTH)) bus ();

  div_cnt_gen #(
    .WIDTH   (WIDTH),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .restart (restart),
    .mode    (mode),
    .bus     (bus),
    .cnt_out (cnt_out),
    .f_out   (f_out),
    .tc      (tc),
    .cfg_err (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst           = 1'b1;
    en            = 1'b0;
    restart       = 1'b0;
    mode          = 1'b0;
    bus.div_valid = 1'b0;
    bus.div_value = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Mid-count reconfiguration: expectations from the transfer edge onward.
  int rc_cnt [9] = '{5, 4, 3, 2, 1, 3, 2, 1, 3};
  int rc_rdy [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
  int rc_tc  [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
  int rc_f   [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};

  // Pulse mode with hold, P=4, starting from cnt_out=4 after restart.
  int ph_en  [17] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int ph_cnt [17] = '{3, 2, 1, 4, 3, 2, 2, 2, 2, 2, 2, 1, 4, 3, 2, 1, 4};
  int ph_tc  [17] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
  int ph_fp  [17] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
  int ph_ft  [17] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};

  initial begin
    int tc_cnt;
    int exp_cnt;

    // Reset defaults
    reset_dut();
    check("rst_cnt",   cnt_out,       10);
    check("rst_f",     f_out,         0);
    check("rst_tc",    tc,            0);
    check("rst_ready", bus.div_ready, 1);
    check("rst_err",   cfg_err,       0);

    // Toggle mode, 40 enabled cycles
    mode   = 1'b0;
    en     = 1'b1;
    tc_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_cnt = (k % 10 == 0) ? 10 : 10 - (k % 10);
      check("tgl_cnt", cnt_out, exp_cnt);
      check("tgl_f",   f_out,   (k / 10) % 2);
      check("tgl_tc",  tc,      (k % 10 == 0) ? 1 : 0);
      if (tc) tc_cnt++;
    end
    check("tgl_tc_count", tc_cnt, 4);

    // Mid-count reconfiguration to P=3 offered while cnt_out=6
    for (int k = 0; k < 4; k++) tick();
    check("rc_cnt_pre",   cnt_out,       6);
    check("rc_ready_pre", bus.div_ready, 1);
    bus.div_valid = 1'b1;
    bus.div_value = 4'd3;
    for (int e = 0; e < 9; e++) begin
      tick();
      bus.div_valid = 1'b0;
      check("rc_cnt",   cnt_out,       rc_cnt[e]);
      check("rc_ready", bus.div_ready, rc_rdy[e]);
      check("rc_tc",    tc,            rc_tc[e]);
      check("rc_f",     f_out,         rc_f[e]);
    end

    // Zero period: accepted, discarded, sticky error, period stays 10
    reset_dut();
    en            = 1'b1;
    bus.div_valid = 1'b1;
    bus.div_value = 4'd0;
    tick();
    bus.div_valid = 1'b0;
    check("zero_cnt",   cnt_out,       9);
    check("zero_err",   cfg_err,       1);
    check("zero_ready", bus.div_ready, 1);
    for (int j = 2; j <= 10; j++) begin
      tick();
      exp_cnt = (j == 10) ? 10 : 10 - j;
      check("zero_cnt_run", cnt_out, exp_cnt);
    end
    check("zero_tc_reload", tc,      1);
    check("zero_err_held",  cfg_err, 1);

    // Reset while a period is pending: the pending value is dropped
    bus.div_valid = 1'b1;
    bus.div_value = 4'd5;
    tick();
    bus.div_valid = 1'b0;
    check("prst_ready_busy", bus.div_ready, 0);
    reset_dut();
    check("prst_err_clr", cfg_err,       0);
    check("prst_ready",   bus.div_ready, 1);
    check("prst_cnt",     cnt_out,       10);
    en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 5) check("prst_no_p5", tc, 0);
    end
    check("prst_cnt_p10", cnt_out, 10);
    check("prst_tc_p10",  tc,      1);

    // Restart with a same-cycle transfer of 7 while cnt_out=5
    for (int j = 0; j < 5; j++) tick();
    check("rx_cnt_pre", cnt_out, 5);
    check("rx_f_pre",   f_out,   1);
    restart       = 1'b1;
    bus.div_valid = 1'b1;
    bus.div_value = 4'd7;
    tick();
    restart       = 1'b0;
    bus.div_valid = 1'b0;
    check("rx_cnt", cnt_out, 7);
    check("rx_f",   f_out,   0);
    check("rx_tc",  tc,      0);
    for (int j = 1; j <= 7; j++) begin
      tick();
      exp_cnt = (j == 7) ? 7 : 7 - j;
      check("rx_cnt_run", cnt_out, exp_cnt);
    end
    check("rx_tc_reload", tc,    1);
    check("rx_f_reload",  f_out, 1);

    // HOLD freezes everything; restart still works in HOLD
    for (int j = 0; j < 3; j++) tick();
    check("hold_cnt_pre", cnt_out, 4);
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("hold_cnt", cnt_out, 4);
      check("hold_tc",  tc,      0);
      check("hold_f",   f_out,   1);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("hold_rs_cnt", cnt_out, 7);
    check("hold_rs_f",   f_out,   0);
    tick();
    check("hold_rs_frozen", cnt_out, 7);

    // Pulse mode with hold, P=4 loaded during HOLD then applied by restart
    mode          = 1'b1;
    bus.div_valid = 1'b1;
    bus.div_value = 4'd4;
    tick();
    bus.div_valid = 1'b0;
    check("ph_ready_busy", bus.div_ready, 0);
    check("ph_cnt_frozen", cnt_out,       7);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("ph_rs_cnt",   cnt_out,       4);
    check("ph_rs_f",     f_out,         0);
    check("ph_rs_ready", bus.div_ready, 0);
    for (int i = 0; i < 17; i++) begin
      en = ph_en[i][0];
      tick();
      check("ph_cnt", cnt_out, ph_cnt[i]);
      check("ph_tc",  tc,      ph_tc[i]);
      check("ph_f",   f_out,   PULSE_BUILD ? ph_fp[i] : ph_ft[i]);
      if (i == 0) check("ph_ready_back", bus.div_ready, 1);
    end

    // P==1: reload on every enabled cycle
    en            = 1'b0;
    mode          = 1'b0;
    bus.div_valid = 1'b1;
    bus.div_value = 4'd1;
    tick();
    bus.div_valid = 1'b0;
    restart       = 1'b1;
    tick();
    restart = 1'b0;
    check("p1_rs_cnt", cnt_out, 1);
    check("p1_rs_f",   f_out,   0);
    en = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("p1_cnt", cnt_out, 1);
      check("p1_tc",  tc,      1);
      check("p1_f",   f_out,   j % 2);
    end
    check("end_err", cfg_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_div_cnt_gen
